// File: rtl/jt51_phacc.sv
// jt51_phacc: time-multiplexed phase accumulator for the 32 operator slots.
// Each enabled cycle advances one slot: the accumulator is incremented (or
// cleared on key-on), the phase modulation offset is added to the phase MSBs,
// and the registered phase is folded into sign / ROM row / ROM address / LSB
// for the phase ROM that follows.
module jt51_phacc #(
  parameter int ACC_W = 20,
  parameter int PH_W  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic [ACC_W-1:0] phinc,
  input  logic             pg_rst,
  input  logic [PH_W-1:0]  pm,
  output logic [4:0]       slot,
  output logic [PH_W-1:0]  phase,
  output logic             ph_sign,
  output logic [1:0]       phrom_sel,
  output logic [4:0]       phrom_addr,
  output logic             ph_lsb
);

  // Quarter-wave fold: the second and fourth quarters read the ROM backwards.
  function automatic logic [7:0] fold_m(input logic [PH_W-1:0] ph);
    logic [7:0] m;
    if (ph[8]) begin
      m = ~ph[7:0];
    end else begin
      m = ph[7:0];
    end
    return m;
  endfunction

  logic [ACC_W-1:0] acc_r [0:31];
  logic [4:0]       cnt_r;
  logic [4:0]       slot_r;
  logic [PH_W-1:0]  phase_r;

  logic [ACC_W-1:0] acc_sum_s;
  logic [ACC_W-1:0] acc_new_s;
  logic [PH_W-1:0]  phase_new_s;
  logic [7:0]       m_s;

  // Next accumulator and modulated phase for the slot selected by the counter.
  always_comb begin
    acc_sum_s = acc_r[cnt_r] + phinc;
    if (pg_rst) begin
      acc_new_s = {ACC_W{1'b0}};
    end else begin
      acc_new_s = acc_sum_s;
    end
    phase_new_s = acc_new_s[ACC_W-1 -: PH_W] + pm;
  end

  // Slot counter, accumulator store and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= 5'd0;
      slot_r  <= 5'd0;
      phase_r <= {PH_W{1'b0}};
      for (int i = 0; i < 32; i++) begin
        acc_r[i] <= {ACC_W{1'b0}};
      end
    end else if (cen) begin
      acc_r[cnt_r] <= acc_new_s;
      cnt_r        <= cnt_r + 5'd1;
      slot_r       <= cnt_r;
      phase_r      <= phase_new_s;
    end
  end

  // Fold the registered phase into the ROM-facing fields.
  always_comb begin
    m_s        = fold_m(phase_r);
    slot       = slot_r;
    phase      = phase_r;
    ph_sign    = phase_r[PH_W-1];
    phrom_sel  = m_s[7:6];
    phrom_addr = m_s[5:1];
    ph_lsb     = m_s[0];
  end

endmodule

// File: tb/tb_jt51_phacc.sv
// tb_jt51_phacc: scoreboard bench for the phase accumulator. Stimulus tasks
// drive inputs and push expected (slot, phase) pairs from an array model;
// a negedge monitor pops and compares whenever an enabled edge produced output,
// and otherwise checks that outputs hold (or read zero after reset).
module tb_jt51_phacc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen = 1'b0;
  logic [19:0] phinc = 20'd0;
  logic        pg_rst = 1'b0;
  logic [9:0]  pm = 10'd0;
  logic [4:0]  slot;
  logic [9:0]  phase;
  logic        ph_sign;
  logic [1:0]  phrom_sel;
  logic [4:0]  phrom_addr;
  logic        ph_lsb;

  jt51_phacc dut (
    .clk(clk), .rst(rst), .cen(cen), .phinc(phinc), .pg_rst(pg_rst), .pm(pm),
    .slot(slot), .phase(phase), .ph_sign(ph_sign), .phrom_sel(phrom_sel),
    .phrom_addr(phrom_addr), .ph_lsb(ph_lsb)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] slot;
    logic [9:0] phase;
  } exp_t;

  exp_t q[$];
  exp_t last_e;
  exp_t mon_e;
  int total = 0;
  int bad = 0;

  // Reference model: plain integer accumulators, one per slot.
  int unsigned m_acc [32];
  int unsigned m_cnt = 0;

  bit en_q = 1'b0;
  bit rst_q = 1'b0;
  bit armed = 1'b0;

  always @(posedge clk) begin
    en_q  <= cen && !rst;
    rst_q <= rst;
  end

  task automatic cmp(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_outputs(input exp_t e);
    int low, m;
    low = e.phase % 256;
    m = ((e.phase / 256) % 2 == 1) ? 255 - low : low;
    cmp("slot", slot, e.slot);
    cmp("phase", phase, e.phase);
    cmp("ph_sign", ph_sign, (e.phase >= 512) ? 1 : 0);
    cmp("phrom_sel", phrom_sel, m / 64);
    cmp("phrom_addr", phrom_addr, (m / 2) % 32);
    cmp("ph_lsb", ph_lsb, m % 2);
  endtask

  // Monitor: compare on enabled edges, check hold otherwise.
  always @(negedge clk) begin
    if (rst_q) begin
      armed = 1'b1;
      q.delete();
      last_e = '0;
      check_outputs(last_e);
    end else if (armed) begin
      if (en_q) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: slot %0d with empty queue", slot);
        end else begin
          mon_e = q.pop_front();
          check_outputs(mon_e);
          last_e = mon_e;
        end
      end else begin
        check_outputs(last_e);
      end
    end
  end

  task automatic step(input logic c, input logic [19:0] inc, input logic pg,
                      input logic [9:0] p);
    exp_t e;
    int unsigned nv;
    @(posedge clk);
    #1;
    cen = c; phinc = inc; pg_rst = pg; pm = p;
    if (c) begin
      nv = pg ? 0 : ((m_acc[m_cnt] + inc) % 32'h100000);
      m_acc[m_cnt] = nv;
      e.slot = m_cnt[4:0];
      e.phase = 10'(((nv / 1024) + p) % 1024);
      q.push_back(e);
      m_cnt = (m_cnt + 1) % 32;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    cen = 1'($urandom_range(0, 1));
    phinc = 20'($urandom);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cen = 1'b0;
    for (int i = 0; i < 32; i++) m_acc[i] = 0;
    m_cnt = 0;
  endtask

  // One full round with traffic only on the target slot; optional cen hole.
  task automatic round(input int tgt, input logic [19:0] inc, input logic pg,
                       input logic [9:0] p, input bit hole);
    for (int s = 0; s < 32; s++) begin
      if (hole && s == 10) begin
        for (int k = 0; k < 5; k++)
          step(1'b0, 20'($urandom), 1'($urandom), 10'($urandom));
      end
      if (s == tgt) step(1'b1, inc, pg, p);
      else          step(1'b1, 20'd0, 1'b0, 10'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_acc[i] = 0;
    repeat (2) @(posedge clk);
    do_reset();

    // Random traffic, then a reset mid-sequence.
    for (int i = 0; i < 150; i++)
      step(1'($urandom_range(0, 3) != 0), 20'($urandom),
           1'($urandom_range(0, 15) == 0), 10'($urandom));
    do_reset();

    // Steady increment on slot 3, with a cen hole in the second round.
    for (int r = 0; r < 4; r++) round(3, 20'h00400, 1'b0, 10'd0, r == 1);

    // Wrap-around on slot 5.
    do_reset();
    for (int r = 0; r < 4; r++) round(5, 20'h80000, 1'b0, 10'd0, 1'b0);

    // Key-on reset on slot 7.
    do_reset();
    round(7, 20'h55400, 1'b0, 10'd0, 1'b0);
    round(7, 20'h00400, 1'b1, 10'h003, 1'b0);
    round(7, 20'h00400, 1'b0, 10'd0, 1'b0);

    // Folding and pm wrap.
    do_reset();
    round(2, 20'h40000, 1'b0, 10'h040, 1'b0);
    do_reset();
    round(4, 20'hFC000, 1'b0, 10'h020, 1'b0);

    // Long random run with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else step(1'($urandom_range(0, 3) != 0), 20'($urandom),
                1'($urandom_range(0, 15) == 0), 10'($urandom));
    end
    step(1'b0, 20'd0, 1'b0, 10'd0);
    repeat (3) @(posedge clk);
    #1;
    cmp("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jt51_phacc.md
Name: jt51_phacc

Overview:
- Time-multiplexed phase accumulator for the 32 operator slots. Sits directly upstream of the phase ROM.
- Each slot advances by one clock-enabled step. Per step the block:
  - adds the slot's phase increment to the slot's 20-bit accumulator;
  - applies phase modulation;
  - folds the 10-bit phase into sign, ROM row select, ROM address and an LSB.
- The ROM consumes the select/address pair on the following enabled cycle.

Parameters:
- ACC_W, 20, accumulator width in bits. Fixed at 20 for this design; 10 MSBs form the phase.
- PH_W, 10, phase width taken from the accumulator MSBs; also the width of pm.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cen  in  1  clock enable; all state advances only when high
- phinc  in  ACC_W  phase increment for the current slot
- pg_rst  in  1  key-on phase reset for the current slot
- pm  in  PH_W  phase modulation offset for the current slot, modulo 2^PH_W
- slot  out  5  index of the slot the outputs belong to
- phase  out  PH_W  modulated phase, registered
- ph_sign  out  1  phase[9]
- phrom_sel  out  2  ROM row select, m[7:6]
- phrom_addr  out  5  ROM address, m[5:1]
- ph_lsb  out  1  m[0]

Behaviour:
- Storage and slot counter
  - 32-entry accumulator store, one ACC_W word per slot. Implement as a circular shift register or RAM; the choice is free.
  - Internal 5-bit slot counter cnt. It increments on every cycle with cen=1 and wraps 31 -> 0.
- Per cycle with cen=1, for slot cnt:
  - acc_new = pg_rst ? 0 : (acc[cnt] + phinc) mod 2^ACC_W.
  - acc[cnt] <= acc_new.
  - phase <= (acc_new[ACC_W-1 -: PH_W] + pm) mod 2^PH_W.
  - slot <= cnt.
  - pg_rst takes priority over phinc. The cleared value 0 is the value used for that same cycle's output, so the output phase equals pm.
- Folding (combinational from the registered phase; all fold outputs update together with phase):
  - ph_sign = phase[9].
  - m[7:0] = phase[8] ? ~phase[7:0] : phase[7:0].
  - phrom_sel = m[7:6], phrom_addr = m[5:1], ph_lsb = m[0].
- Latency: inputs sampled on enabled cycle N appear on the outputs after that edge, tagged with slot = cnt at cycle N.
- Each slot's accumulator is updated exactly once per 32 enabled cycles.
- cen=0: counter, store and all outputs hold. Inputs are ignored.
- Arithmetic: all additions wrap with no saturation. Carry out of the accumulator MSB and out of the pm add is discarded.
- Reset (rst=1 on a clock edge, regardless of cen):
  - cnt=0;
  - all 32 accumulators cleared;
  - slot=0, phase=0, so ph_sign=0, phrom_sel=0, phrom_addr=0, ph_lsb=0.
  - Reset asserted mid-sequence discards all in-flight state.
  - The first enabled cycle after reset release processes slot 0.
- rst and cen both high: reset wins.

Test Plan:
- Reset check: run random traffic, assert rst for 1 cycle -> slot=0, phase=0, phrom_sel=0, phrom_addr=0; next enabled cycle processes slot 0 with acc=0.
- Steady increment: phinc=20'h00400 on slot 3 only (0 elsewhere), pm=0 -> slot-3 phase reads 1,2,3,... on successive 32-cycle rounds; all other slots stay 0.
- Wrap-around: slot 5 with phinc=20'h80000 -> phase 10'h200 (ph_sign=1), then 10'h000, alternating.
- Key-on reset: slot 7 accumulates to phase 10'h155, then pg_rst=1 with phinc=20'h00400 and pm=10'h003 -> phase=10'h003; next round with pg_rst=0, pm=0 -> phase=10'h001.
- Folding and pm: acc phase 10'h100, pm=10'h040 -> phase=10'h140, ph_sign=0, m=8'hBF, phrom_sel=2, phrom_addr=31, ph_lsb=1. Also acc 10'h3F0 with pm=10'h020 -> phase=10'h010 (modulo wrap).
- cen gating: hold cen=0 for 5 cycles mid-round with inputs toggling -> outputs and slot unchanged; sequence resumes at the next slot with no skipped or duplicated update.
